// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive-side decoder for a multiplexed 4-digit
// seven-segment bus. Samples the active-low anode/segment lines, waits for
// STABLE_CYCLES identical samples, decodes the glyph back to a hex value and
// stores it against the digit whose anode is low. Reports completed frames
// and illegal glyphs.
//
// Parameters:
//   STABLE_CYCLES  identical samples required before acceptance (>= 2)
//   CNT_W          stability counter width (must hold STABLE_CYCLES)
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   a..g, dp            segment lines / decimal point, active-low
//   an[3:0]             digit enables, active-low, an[i] selects digit i
//   out0..out3          last accepted value per digit
//   valid[3:0]          digit accepted at least once since reset
//   dp_out[3:0]         captured decimal point per digit, 1 = lit
//   frame_done          pulse once all four digits accepted since last pulse
//   seg_err             pulse when a stable pattern is not a legal glyph
// Build option:
//   SEVEN_SEG_CAPTURE_DP_EN  capture dp and include it in the stability
//                            compare; otherwise dp is ignored and dp_out = 0.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] valid,
  output logic [3:0] dp_out,
  output logic       frame_done,
  output logic       seg_err
);

  // Current (s_*) and previous (p_*) samples; segments kept active-low.
  logic [3:0]       s_an, p_an;
  logic [6:0]       s_seg, p_seg;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       seen;
  logic             pend;
  logic [3:0]       outs [4];

  logic             same, commit, onehot, legal, blank;
  logic [1:0]       idx;
  logic [3:0]       sel;
  logic [6:0]       glyph;
  logic [3:0]       val;

`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic             s_dp, p_dp;
  logic [3:0]       dp_r;
  assign same   = (s_an == p_an) && (s_seg == p_seg) && (s_dp == p_dp);
  assign dp_out = dp_r;
`else
  logic             dp_unused;
  assign dp_unused = dp;
  assign same      = (s_an == p_an) && (s_seg == p_seg);
  assign dp_out    = '0;
`endif

  // Commit only on the step into saturation so a held pattern fires once.
  assign commit = same && (cnt == CNT_W'(STABLE_CYCLES - 1));
  assign glyph  = ~s_seg;
  assign blank  = (glyph == '0);
  assign sel    = ~s_an;

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (s_an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    val   = '0;
    case (glyph)
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_an       <= '1;
      p_an       <= '1;
      s_seg      <= '1;
      p_seg      <= '1;
      cnt        <= '0;
      seen       <= '0;
      pend       <= 1'b0;
      valid      <= '0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) outs[i] <= '0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      s_dp       <= 1'b1;
      p_dp       <= 1'b1;
      dp_r       <= '0;
`endif
    end else begin
      s_an  <= an;
      s_seg <= {g, f, e, d, c, b, a};
      p_an  <= s_an;
      p_seg <= s_seg;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      s_dp  <= dp;
      p_dp  <= s_dp;
`endif
      if (same) begin
        if (cnt < CNT_W'(STABLE_CYCLES)) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= CNT_W'(1);
      end

      seg_err    <= 1'b0;
      frame_done <= pend;
      pend       <= 1'b0;

      // Anodes that are not one-hot are ignored silently; blank is a no-op.
      if (commit && onehot && !blank) begin
        if (legal) begin
          outs[idx]  <= val;
          valid[idx] <= 1'b1;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
          dp_r[idx]  <= ~s_dp;
`endif
          if ((seen | sel) == 4'b1111) begin
            seen <= '0;
            pend <= 1'b1;
          end else begin
            seen <= seen | sel;
          end
        end else begin
          seg_err <= 1'b1;
        end
      end
    end
  end

  assign out0 = outs[0];
  assign out1 = outs[1];
  assign out2 = outs[2];
  assign out3 = outs[3];

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;
  localparam int S = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a, b, c, d, e, f, g;
  logic       dp = 1'b1;
  logic [3:0] an = 4'hF;
  logic [6:0] segl = 7'h7F;   // active-low {g..a}
  logic [3:0] out0, out1, out2, out3, valid, dp_out;
  logic       frame_done, seg_err;

  assign {g, f, e, d, c, b, a} = segl;

  always #5 clock = ~clock;

  seven_seg_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .dp_out(dp_out), .frame_done(frame_done), .seg_err(seg_err)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-high gfedcba glyphs indexed by hex value.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------- behavioural model ----------------
  logic [11:0] hist [$];
  logic [3:0]  m_out [4];
  logic [3:0]  m_valid, m_dp, m_seen;
  logic        m_pend, m_fd, m_err;
  bit          model_ok = 0;
  int          fd_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] fd_snap [$];

  function automatic logic [11:0] pack(input logic [3:0] an_v, input logic dp_v, input logic [6:0] seg_v);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    return {an_v, dp_v, seg_v};
`else
    return {an_v, 1'b1, seg_v};
`endif
  endfunction

  task automatic apply(input logic [11:0] v);
    logic [3:0] low;
    logic [6:0] gl;
    int idx, hit;
    low = ~v[11:8];
    if ($countones(low) != 1) return;
    idx = 0;
    for (int i = 0; i < 4; i++) if (low[i]) idx = i;
    gl = ~v[6:0];
    if (gl == 7'h00) return;
    hit = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == gl) hit = i;
    if (hit < 0) begin
      m_err = 1'b1;
      return;
    end
    m_out[idx]   = hit[3:0];
    m_valid[idx] = 1'b1;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    m_dp[idx]    = ~v[7];
`endif
    m_seen = m_seen | low;
    if (m_seen == 4'hF) begin
      m_seen = 4'h0;
      m_pend = 1'b1;
    end
  endtask

  initial begin
    logic [11:0] cur;
    int n;
    bit cm;
    forever begin
      @(posedge clock);
      cur = pack(an, dp, segl);
      if (reset) begin
        for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
        m_valid = '0; m_dp = '0; m_seen = '0;
        m_pend = 0; m_fd = 0; m_err = 0;
        hist = '{12'hFFF};
        model_ok = 1;
      end else if (model_ok) begin
        m_fd = m_pend;
        m_pend = 0;
        m_err = 0;
        n = hist.size();
        // A commit needs the last S samples identical and not part of a longer run.
        cm = (n >= S);
        if (cm) begin
          for (int k = 1; k < S; k++) if (hist[n-1-k] != hist[n-1]) cm = 0;
          if (n > S && hist[n-1-S] == hist[n-1]) cm = 0;
        end
        if (cm) apply(hist[n-1]);
        hist.push_back(cur);
        if (hist.size() > S + 1) void'(hist.pop_front());
      end
      @(negedge clock);
      if (model_ok) begin
        check("out0", out0, m_out[0]);
        check("out1", out1, m_out[1]);
        check("out2", out2, m_out[2]);
        check("out3", out3, m_out[3]);
        check("valid", valid, m_valid);
        check("dp_out", dp_out, m_dp);
        check("frame_done", frame_done, m_fd);
        check("seg_err", seg_err, m_err);
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_snap.push_back({out3, out2, out1, out0});
        end
        if (seg_err === 1'b1) err_cnt++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic hold(input logic [3:0] a_n, input logic [6:0] s, input logic dv, input int cyc);
    an = a_n; segl = s; dp = dv;
    repeat (cyc) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    an = 4'hF; segl = 7'h7F; dp = 1'b1;
    reset = 1'b1;
    repeat (cyc) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic scan(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2, input logic [3:0] v3);
    logic [3:0] vals [4];
    logic [3:0] sel;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int i = 0; i < 4; i++) begin
      sel = 4'b0001 << i;
      hold(~sel, ~glyph[vals[i]], 1'b1, 8);
    end
  endtask

  initial begin
    int f0, e0;
    // Reset
    do_reset(3);
    check("rst_out0", out0, 0);
    check("rst_out3", out3, 0);
    check("rst_valid", valid, 0);
    check("rst_pulses", {frame_done, seg_err}, 0);

    // Single digit 5 on digit 0: accepted on the 5th edge after it is applied.
    an = 4'b1110; segl = 7'h12; dp = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("single_pre_out0", out0, 0);
    @(posedge clock); #1;
    check("single_out0", out0, 5);
    check("single_valid", valid, 4'b0001);
    repeat (3) @(posedge clock);
    #1;
    check("single_nofd", fd_cnt, 0);

    // Two full scan frames
    do_reset(1);
    f0 = fd_cnt;
    scan(4'h0, 4'h1, 4'h0, 4'h5);
    scan(4'h4, 4'h9, 4'h9, 4'h9);
    hold(4'hF, 7'h7F, 1'b1, 3);
    check("scan_fd_count", fd_cnt - f0, 2);
    if (fd_snap.size() >= f0 + 2) begin
      check("scan_frame1", fd_snap[f0], 16'h5010);
      check("scan_frame2", fd_snap[f0 + 1], 16'h9994);
    end else begin
      check("scan_snap_avail", fd_snap.size(), f0 + 2);
    end

    // Glitch: 3 samples only
    do_reset(1);
    hold(4'b1011, ~glyph[9], 1'b1, 3);
    hold(4'b1111, ~glyph[9], 1'b1, 8);
    check("glitch_out2", out2, 0);
    check("glitch_valid", valid, 0);

    // Illegal glyph, blank, and non-one-hot anodes
    e0 = err_cnt;
    hold(4'b1101, ~7'h49, 1'b1, 8);
    check("err_count", err_cnt - e0, 1);
    check("err_out1", out1, 0);
    hold(4'b1110, 7'h7F, 1'b1, 8);
    check("blank_out0", out0, 0);
    hold(4'b1100, ~glyph[5], 1'b1, 8);
    check("twohot_err", err_cnt - e0, 1);
    check("twohot_valid", valid, 0);

    // Mid-frame reset clears the seen mask
    do_reset(1);
    hold(4'b1110, ~glyph[3], 1'b1, 8);
    hold(4'b1101, ~glyph[7], 1'b1, 8);
    check("mid_valid", valid, 4'b0011);
    do_reset(1);
    check("mid_rst_valid", valid, 0);
    f0 = fd_cnt;
    hold(4'b1011, ~glyph[6], 1'b1, 8);
    hold(4'b0111, ~glyph[10], 1'b1, 8);
    check("mid_no_fd", fd_cnt - f0, 0);
    hold(4'b1110, ~glyph[1], 1'b1, 8);
    hold(4'b1101, ~glyph[2], 1'b1, 8);
    hold(4'hF, 7'h7F, 1'b1, 2);
    check("mid_fd", fd_cnt - f0, 1);

    // Reset coinciding with the commit edge wins
    do_reset(1);
    hold(4'b1110, ~glyph[8], 1'b1, 4);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_prio_out0", out0, 0);
    check("rst_prio_valid", valid, 0);
    hold(4'hF, 7'h7F, 1'b1, 2);

    // Decimal point
    do_reset(1);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    hold(4'b0111, ~glyph[3], 1'b0, 8);
    check("dp_out", dp_out, 4'b1000);
    check("dp_out3", out3, 3);
`else
    hold(4'b0111, ~glyph[3], 1'b1, 2);
    hold(4'b0111, ~glyph[3], 1'b0, 1);
    hold(4'b0111, ~glyph[3], 1'b1, 1);
    check("dp_ign_pre", out3, 0);
    hold(4'b0111, ~glyph[3], 1'b1, 1);
    check("dp_ign_out3", out3, 3);
    check("dp_out_zero", dp_out, 0);
`endif
    hold(4'hF, 7'h7F, 1'b1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side decoder for the multiplexed 4-digit seven-segment bus driven by `Seven_seg`. It samples the time-multiplexed cathode and anode lines and waits for each pattern to be stable before accepting it. Each pattern is decoded back to a 4-bit hex digit and stored per digit position. Completed scan frames are reported so that loopback benches and on-board self-test can check display contents against the values sent.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is accepted; minimum 2.
- `CNT_W`, 8: width of the stability counter; must hold `STABLE_CYCLES`.

- `clock`  in  1  single clock domain; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a`..`g`  in  1 each  segment lines, active-low (0 = segment lit).
- `dp`  in  1  decimal point, active-low.
- `an`  in  4  digit enables, active-low; `an[i]` selects digit i.
- `out0`..`out3`  out  4 each  last accepted value for digits 0..3.
- `valid`  out  4  `valid[i]` is 1 once digit i has been accepted at least once since reset.
- `dp_out`  out  4  captured decimal point per digit, 1 = lit (see Configuration).
- `frame_done`  out  1  one-cycle pulse when all four digits have been accepted since the last pulse.
- `seg_err`  out  1  one-cycle pulse when a stable pattern is not a legal hex glyph.

## Operation
- Input register: `{an, dp, g..a}` is registered every cycle as `s_an` and `s_seg`.
  - Reset values: `s_an = 4'b1111`, `s_seg` = all off.
- Stability counter `cnt`:
  - If the current sample equals the previous sample, `cnt` increments and saturates at `STABLE_CYCLES`.
  - Otherwise `cnt` = 1.
- Commit event: fires on the single cycle where `cnt` steps from `STABLE_CYCLES-1` to `STABLE_CYCLES`.
  - There is exactly one commit per stable window.
  - A held pattern never recommits.
- Anode check at commit: `s_an` must have exactly one 0 bit.
  - If all ones, or two or more zeros: no update, no error pulse, mask unchanged.
- Decode, active-high gfedcba to value:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
- Legal glyph with one-hot anode i:
  - `out<i>` ← value, `valid[i]` ← 1, `seen[i]` ← 1.
- Blank pattern (00): no update, no error.
- Any other pattern: `seg_err` pulses.
  - `out<i>`, `valid` and `seen` are unchanged.
- Frame tracking, internal 4-bit `seen` mask:
  - When the commit makes `seen == 4'b1111`, `frame_done` pulses on the following cycle and `seen` clears to 0000.
  - Re-committing a digit already seen is allowed and does not count twice.

## Timing
- Latency: with inputs constant from before edge k, the commit happens at edge k+`STABLE_CYCLES`.
  - `out<i>`, `valid`, `seg_err` and `dp_out` change at that edge.
- `frame_done` is asserted for one cycle, after edge k+`STABLE_CYCLES`+1.
- A change at any edge before the commit restarts the count. Glitches shorter than `STABLE_CYCLES` samples are rejected.
- Reset, at any point including mid-window:
  - At the next edge, all outputs are 0 and `valid = 0`.
  - `seen = 0`, `cnt = 0`, and the sample registers return to their reset values.
- `reset` has priority over a commit on the same edge.

## Configuration
- `SEVEN_SEG_CAPTURE_DP_EN` defined:
  - `dp` takes part in the stability compare.
  - On a legal-glyph commit, `dp_out[i]` ← `~dp`.
  - A blank glyph with `dp` lit is treated as blank: no update.
- Undefined:
  - `dp` is ignored everywhere and `dp_out` is tied to 4'b0000.
  - Toggling `dp` does not restart stability.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and a 10 ns clock.
- Reset:
  - Stimulus: hold `reset` 3 cycles.
  - Response: all outputs 0, `valid`=0000, no pulses.
- Single digit:
  - Stimulus: `an`=1110, segments for 5 (active-low 0x12), held 8 cycles.
  - Response: `out0`=5 and `valid`=0001 at the 4th edge after the first sample; exactly one commit; no `frame_done`.
- Scan frame:
  - Stimulus: scan digits 0..3 with values 0,1,0,5, 8 cycles each, then values 4,9,9,9.
  - Response: first `frame_done` pulse with outs 0,1,0,5; second pulse with outs 4,9,9,9.
- Glitch rejection:
  - Stimulus: digit 2 with the 9 glyph for 3 cycles, then `an`=1111.
  - Response: `out2` unchanged, `valid[2]`=0.
- Errors:
  - Stimulus: stable 0x49 (active-high) on `an`=1101.
  - Response: one `seg_err` pulse, `out1` unchanged.
  - Stimulus: stable `an`=1100.
  - Response: no commit, no pulse.
- Mid-frame reset and DP:
  - Stimulus: reset after 2 digits are committed.
  - Response: `seen` cleared; a full 4-digit scan is needed before `frame_done`.
  - With `SEVEN_SEG_CAPTURE_DP_EN`, stimulus: `dp`=0 on digit 3.
  - Response: `dp_out`=1000.
